product_accumulator: RTL
========================

// Module: product_accumulator
// PURPOSE
//   Downstream stage of the signed multiplier: accumulates a frame of N_TAPS
//   signed products (one per accepted beat) into one filter-output sample.
//   Saturating accumulator with round-half-up output scaling and a per-frame
//   overflow flag; valid/ready handshake on both sides. Produces the LMS
//   filter output y(n) that feeds error computation.
// PARAMETERS
//   P_W       16  product input width (matches multiplier result width)
//   N_TAPS    8   products per frame (>=2)
//   ACC_W     19  accumulator width (>= P_W; P_W+clog2(N_TAPS) is overflow-free)
//   OUT_W     16  output width (<= ACC_W)
//   OUT_SHIFT 3   arithmetic right shift applied to final sum (0 = none)
// PORTS
//   clk       in   1                clock, all state on rising edge
//   rst_n     in   1                asynchronous active-low reset
//   clear     in   1                synchronous frame abort
//   in_valid  in   1                product beat valid
//   in_data   in   P_W              signed product
//   in_ready  out  1                block accepts a beat
//   out_valid out  1                out_data/out_ovf valid
//   out_data  out  OUT_W            signed scaled sum
//   out_ovf   out  1                saturation occurred in this frame
//   out_ready in   1                consumer takes the result
//   tap_idx   out  clog2(N_TAPS)    index of next beat to be accepted
// BEHAVIOUR
//   Reset (rst_n=0, async): state=ACCUM, acc=0, tap_idx=0, out_valid=0,
//     out_data=0, out_ovf=0; in_ready=1 once out of reset.
//   States: ACCUM (in_ready=1, out_valid=0), HOLD (in_ready=0, out_valid=1).
//   ACCUM: beat accepted when in_valid&in_ready. tap_idx=0: acc <= sext(in_data)
//     (load, no clear cycle). Else acc <= sat_ACC_W(acc + sext(in_data)),
//     sum formed at ACC_W+1 bits. tap_idx increments per beat; idle cycles
//     (in_valid=0) hold all state.
//   Last beat (tap_idx=N_TAPS-1): final sum saturated as above, then
//     scaled: r = (sum + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT at ACC_W+1 bits
//     (no add when OUT_SHIFT=0), then saturated to OUT_W. out_data<=r,
//     out_valid<=1 next cycle (latency 1 from last beat), state->HOLD,
//     tap_idx->0.
//   out_ovf = OR of every accumulator clamp in the frame and the output clamp;
//     sticky over the frame, reloaded at each new frame.
//   HOLD: out_data/out_ovf stable while out_valid&!out_ready; in_valid ignored.
//     On out_valid&out_ready: out_valid<=0, state->ACCUM next cycle (one
//     bubble cycle per frame; no overlapping frames).
//   Saturation clamps to +(2^(W-1)-1) / -2^(W-1) of target width W.
//   clear=1: synchronous, overrides all other actions that cycle: state=ACCUM,
//     acc=0, tap_idx=0, out_valid=0, ovf=0; beat presented that cycle dropped.
//   Reset mid-frame or in HOLD: all outputs zero immediately; partial frame lost.
// TESTING (defaults unless stated)
//   8 beats of +1000, out_ready=1 -> out_data=1000, out_ovf=0, out_valid 1 cycle after 8th beat.
//   Rounding: 7x0 then +12 -> out_data=2; 7x0 then -12 -> out_data=-1; OUT_SHIFT=0, sum 5 -> 5.
//   ACC_W=17: 8 beats of +32767 -> acc clamps 65535, out_data=8192, out_ovf=1; next frame 8x+1 -> out_ovf=0.
//   8 beats of -32768 -> out_data=-32768, out_ovf=0 (exact -2^18, no clamp).
//   out_ready low 5 cycles in HOLD with in_valid=1 -> out_data stable, in_ready=0, no beats taken; next frame starts at tap_idx=0.
//   clear after 3 beats, then 8x+8 -> out_data=8; rst_n low in HOLD -> out_valid=0, out_data=0 without clock edge.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Valid/ready bus between the multiplier stage, the product accumulator and its consumer.
// Latency: none; this file only groups the wires.
// Backpressure: in_ready/out_ready carry the stall in each direction.
interface product_accumulator_if #(
   parameter int P_W   = 16,
   parameter int OUT_W = 16,
   parameter int TAP_W = 3
);
   logic                    in_valid;
   logic signed [P_W-1:0]   in_data;
   logic                    in_ready;
   logic                    out_valid;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_ovf;
   logic                    out_ready;
   logic [TAP_W-1:0]        tap_idx;

   // Producer/consumer side (drives beats, takes results)
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, tap_idx
   );

   // Accumulator side
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ovf, tap_idx
   );
endinterface

// File: rtl/product_accumulator.sv
// Accumulates N_TAPS signed products per frame into one saturated, rounded, scaled sample.
// Latency: result valid 1 cycle after the last beat of a frame; one bubble cycle per frame.
// Backpressure: in_ready drops while a result is held; the result is held until out_ready.
module product_accumulator #(
   parameter int P_W       = 16,
   parameter int N_TAPS    = 8,
   parameter int ACC_W     = 19,
   parameter int OUT_W     = 16,
   parameter int OUT_SHIFT = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   product_accumulator_if.slave bus
);

   localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
   localparam int L_HSH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

   // Rounding constant 2^(OUT_SHIFT-1); zero when no scaling is applied
   localparam logic signed [ACC_W:0] L_HALF =
      (OUT_SHIFT == 0) ? '0 : ({{ACC_W{1'b0}}, 1'b1} << L_HSH);
   // Output clamp limits expressed at the ACC_W+1 working width
   localparam logic signed [ACC_W:0] L_OMAX =
      $signed({{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}});
   localparam logic signed [ACC_W:0] L_OMIN =
      $signed({{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}});

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic signed [ACC_W-1:0] r_acc;
   logic [TAP_W-1:0]        r_tap;
   logic                    r_ovf;
   logic signed [OUT_W-1:0] r_out_data;
   logic                    r_out_ovf;

   logic                    w_beat;
   logic                    w_first;
   logic                    w_last;
   logic signed [ACC_W:0]   w_in_ext;
   logic signed [ACC_W:0]   w_acc_ext;
   logic signed [ACC_W:0]   w_sum;
   logic                    w_aclamp;
   logic signed [ACC_W-1:0] w_acc_sat;
   logic signed [ACC_W:0]   w_sat_ext;
   logic signed [ACC_W:0]   w_rnd;
   logic signed [ACC_W:0]   w_shf;
   logic                    w_ohi;
   logic                    w_olo;
   logic signed [OUT_W-1:0] w_out;
   logic                    w_frame_ovf;

   assign w_beat  = (r_state == ACCUM) && bus.in_valid;
   assign w_first = (r_tap == '0);
   assign w_last  = (r_tap == TAP_W'(N_TAPS - 1));

   // Sum is formed one bit wider than the accumulator so a clamp can be detected
   assign w_in_ext  = {{(ACC_W + 1 - P_W){bus.in_data[P_W-1]}}, bus.in_data};
   assign w_acc_ext = {r_acc[ACC_W-1], r_acc};

   // First beat of a frame loads instead of adding, so no clear cycle is needed
   always_comb begin
      w_sum     = w_first ? w_in_ext : (w_acc_ext + w_in_ext);
      w_aclamp  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
      w_acc_sat = w_sum[ACC_W-1:0];
      if (w_aclamp) begin
         w_acc_sat = w_sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                  : {1'b0, {(ACC_W - 1){1'b1}}};
      end
   end

   // Round half up, arithmetic shift, then clamp into the output width
   always_comb begin
      w_sat_ext = {w_acc_sat[ACC_W-1], w_acc_sat};
      w_rnd     = w_sat_ext + L_HALF;
      w_shf     = w_rnd >>> OUT_SHIFT;
      w_ohi     = (w_shf > L_OMAX);
      w_olo     = (w_shf < L_OMIN);
      w_out     = w_shf[OUT_W-1:0];
      if (w_ohi) begin
         w_out = L_OMAX[OUT_W-1:0];
      end else if (w_olo) begin
         w_out = L_OMIN[OUT_W-1:0];
      end
   end

   // Overflow is sticky within a frame and restarts with the first beat
   assign w_frame_ovf = (w_first ? 1'b0 : r_ovf) | w_aclamp;

   // Frame state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: HOLD after the last beat, back to ACCUM once the result is taken
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ACCUM:   if (w_beat && w_last) w_state_nxt = HOLD;
         HOLD:    if (bus.out_ready)    w_state_nxt = ACCUM;
         default: w_state_nxt = ACCUM;
      endcase
      if (clear) begin
         w_state_nxt = ACCUM;
      end
   end

   // Accumulator, tap counter and result registers; clear wins over a beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_tap      <= '0;
         r_ovf      <= 1'b0;
         r_out_data <= '0;
         r_out_ovf  <= 1'b0;
      end else if (clear) begin
         r_acc     <= '0;
         r_tap     <= '0;
         r_ovf     <= 1'b0;
         r_out_ovf <= 1'b0;
      end else if (w_beat) begin
         r_acc <= w_acc_sat;
         r_ovf <= w_frame_ovf;
         if (w_last) begin
            r_tap      <= '0;
            r_out_data <= w_out;
            r_out_ovf  <= w_frame_ovf | w_ohi | w_olo;
         end else begin
            r_tap <= r_tap + TAP_W'(1);
         end
      end
   end

   assign bus.in_ready  = (r_state == ACCUM);
   assign bus.out_valid = (r_state == HOLD);
   assign bus.out_data  = r_out_data;
   assign bus.out_ovf   = r_out_ovf;
   assign bus.tap_idx   = r_tap;

endmodule
